// File: rtl/mod_n_cascade_counter.sv
// Multi-digit modulo-RADIX up/down counter with synchronous parallel load,
// per-digit load range checking and a combinational cascade carry-out (TC).
module mod_n_cascade_counter #(
  parameter int DIGITS = 4,
  parameter int RADIX  = 10,
  parameter int DW     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 counter_on,
  input  logic                 carry_in,
  input  logic                 count_up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] data_in,
  output logic [DIGITS*DW-1:0] count,
  output logic                 TC,
  output logic                 load_err
);

  // The range compare is one bit wider than a digit so RADIX = 2**DW
  // does not wrap to zero and reject every value.
  localparam logic [DW-1:0] MAX_DIGIT = DW'(RADIX - 1);
  localparam logic [DW:0]   RADIX_EXT = (DW + 1)'(RADIX);

  logic [DIGITS*DW-1:0] step_value;
  logic [DIGITS*DW-1:0] load_value;
  logic [DIGITS:0]      ripple;
  logic [DIGITS-1:0]    digit_bad;

  // ripple[i] = every digit below i sits at the terminal value for the
  // current direction, so digit i moves on this step.
  assign ripple[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DW-1:0] digit;
    logic [DW-1:0] in_digit;
    logic          digit_term;

    assign digit      = count[i*DW +: DW];
    assign digit_term = count_up ? (digit == MAX_DIGIT) : (digit == '0);

    assign step_value[i*DW +: DW] =
        !ripple[i] ? digit :
        digit_term ? (count_up ? '0 : MAX_DIGIT) :
        count_up   ? digit + 1'b1 : digit - 1'b1;

    assign ripple[i+1] = ripple[i] & digit_term;

    assign in_digit               = data_in[i*DW +: DW];
    assign digit_bad[i]           = {1'b0, in_digit} >= RADIX_EXT;
    assign load_value[i*DW +: DW] = digit_bad[i] ? '0 : in_digit;
  end

  // Pure combinational so the next instance's carry_in sees it this cycle.
  assign TC = counter_on & carry_in & ~load & ~reset & ripple[DIGITS];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let ordering leak between flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      load_err <= 1'b0;
    end else if (load) begin
      count    <= load_value;
      load_err <= |digit_bad;
    end else if (counter_on && carry_in) begin
      count <= step_value;
    end
  end

endmodule
